key_sram_responder: RTL and testbench

- Responder side of the key-schedule SRAM request interface: services single-cycle read/write strobes from the key expansion and round engines against a small 128-bit-word key store.
- Provides an init path that loads the cipher key into a selected word.
- Provides a dump path that streams a selected word out as four 32-bit beats over a valid/ready handshake to the host/debug side.
- Sits between the key-schedule controller and the host interface.

---
 rtl/key_sram_responder.sv | 128 ++++++++++++
 tb/tb_key_sram_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/key_sram_responder.sv
// Key-schedule SRAM responder: 128-bit word store with request, init and
// four-beat dump paths.
module key_sram_responder #(
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [127:0]      write_data,
    output logic [127:0]      read_data,
    output logic              addr_err,
    input  logic              init,
    input  logic [2:0]        init_num,
    input  logic [127:0]      init_data,
    input  logic              dump,
    input  logic [2:0]        dump_num,
    output logic [31:0]       dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_SEND = 2'd1,
        D_DONE = 2'd2
    } dump_state_t;

    localparam logic [ADDR_W-5:0] NW_HI  = (ADDR_W-4)'(NUM_WORDS);
    localparam logic [3:0]        NW_IDX = 4'(NUM_WORDS);

    logic [127:0] mem [NUM_WORDS];
    logic [127:0] snap;
    logic [1:0]   beat;
    dump_state_t  state, state_nxt;

    logic       addr_ok;
    logic [2:0] idx;
    logic       init_ok;
    logic       dump_start;

    assign addr_ok    = (addr[3:0] == 4'd0) && (addr[ADDR_W-1:4] < NW_HI);
    assign idx        = addr[6:4];
    assign init_ok    = init && ({1'b0, init_num} < NW_IDX);
    assign dump_start = (state == D_IDLE) && dump && ({1'b0, dump_num} < NW_IDX);

    // Init is written after the request write so it wins on a shared word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (write && addr_ok) begin
                mem[idx] <= write_data;
            end
            if (init_ok) begin
                mem[init_num] <= init_data;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            read_data <= '0;
            addr_err  <= 1'b0;
        end else begin
            addr_err <= (read || write) && !addr_ok;
            if (read) begin
                read_data <= addr_ok ? mem[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= D_IDLE;
            snap  <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            if (dump_start) begin
                snap <= mem[dump_num];
                beat <= '0;
            end else if (state == D_SEND && dump_ready) begin
                beat <= beat + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        dump_data  = '0;
        case (state)
            D_IDLE: begin
                if (dump_start) begin
                    state_nxt = D_SEND;
                end
            end
            D_SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                case (beat)
                    2'd0:    dump_data = snap[127:96];
                    2'd1:    dump_data = snap[95:64];
                    2'd2:    dump_data = snap[63:32];
                    default: dump_data = snap[31:0];
                endcase
                if (dump_ready && beat == 2'd3) begin
                    state_nxt = D_DONE;
                end
            end
            D_DONE: begin
                dump_done = 1'b1;
                state_nxt = D_IDLE;
            end
            default: state_nxt = D_IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_sram_responder.sv
// Directed self-checking bench for key_sram_responder.
module tb_key_sram_responder;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         read, write, init, dump, dump_ready;
    logic [15:0]  addr;
    logic [127:0] write_data, init_data;
    logic [2:0]   init_num, dump_num;
    logic [127:0] read_data;
    logic         addr_err, dump_valid, dump_busy, dump_done;
    logic [31:0]  dump_data;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] W1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] W2  = 128'hdeadbeef0123456789abcdeffeedface;

    key_sram_responder #(.NUM_WORDS(8), .ADDR_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .read(read), .write(write), .addr(addr),
        .write_data(write_data), .read_data(read_data), .addr_err(addr_err),
        .init(init), .init_num(init_num), .init_data(init_data),
        .dump(dump), .dump_num(dump_num), .dump_data(dump_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_dump(input string tag, input logic v, input logic b,
                            input logic d, input logic [31:0] data);
        chk({tag, ".valid"}, 128'(dump_valid), 128'(v));
        chk({tag, ".busy"},  128'(dump_busy),  128'(b));
        chk({tag, ".done"},  128'(dump_done),  128'(d));
        chk({tag, ".data"},  128'(dump_data),  128'(data));
    endtask

    initial begin
        n_rst = 1'b0; read = 0; write = 0; init = 0; dump = 0; dump_ready = 0;
        addr = '0; write_data = '0; init_data = '0; init_num = '0; dump_num = '0;
        step(); step();
        chk("rst.read_data", read_data, '0);
        chk("rst.addr_err", 128'(addr_err), 0);
        chk_dump("rst", 0, 0, 0, 32'h0);
        n_rst = 1'b1;
        step();

        // Read word 0 after reset
        read = 1; addr = 16'h0000; step(); read = 0;
        chk("rd0.empty", read_data, '0);
        chk("rd0.err", 128'(addr_err), 0);

        // Init word 0 then read
        init = 1; init_num = 3'd0; init_data = KEY; step(); init = 0;
        read = 1; addr = 16'h0000; step(); read = 0;
        chk("rd0.key", read_data, KEY);
        step();
        chk("rd0.hold", read_data, KEY);

        // Same-cycle write/read returns old value
        write = 1; read = 1; addr = 16'h0010; write_data = W1; step();
        write = 0;
        chk("rw1.old", read_data, '0);
        step(); read = 0;
        chk("rd1.new", read_data, W1);

        // Bad addresses
        read = 1; addr = 16'h0014; step(); read = 0;
        chk("bad14.err", 128'(addr_err), 1);
        chk("bad14.rd", read_data, '0);
        step();
        chk("bad14.err_pulse", 128'(addr_err), 0);
        read = 1; addr = 16'h0080; read_data_dummy: begin end
        step(); read = 0;
        chk("bad80.err", 128'(addr_err), 1);
        chk("bad80.rd", read_data, '0);
        write = 1; addr = 16'h0014; write_data = '1; step(); write = 0;
        chk("wbad.err", 128'(addr_err), 1);
        read = 1; addr = 16'h0010; step();
        chk("wbad.w1", read_data, W1);
        addr = 16'h0000; step(); read = 0;
        chk("wbad.w0", read_data, KEY);

        // Dump word 1, ready held high
        dump = 1; dump_num = 3'd1; dump_ready = 1; step(); dump = 0;
        chk_dump("d1.b0", 1, 1, 0, 32'ha0fafe17); step();
        chk_dump("d1.b1", 1, 1, 0, 32'h88542cb1); step();
        chk_dump("d1.b2", 1, 1, 0, 32'h23a33939); step();
        chk_dump("d1.b3", 1, 1, 0, 32'h2a6c7605); step();
        chk_dump("d1.done", 0, 0, 1, 32'h0); step();
        chk_dump("d1.idle", 0, 0, 0, 32'h0);

        // Dump with ready toggling, mid-dump write, ignored second strobe
        dump = 1; dump_num = 3'd1; dump_ready = 0; step(); dump = 0;
        chk_dump("d2.b0", 1, 1, 0, 32'ha0fafe17);
        dump_ready = 1; write = 1; addr = 16'h0010; write_data = W2;
        dump = 1; dump_num = 3'd0; step();
        write = 0; dump = 0; dump_ready = 0;
        chk_dump("d2.b1", 1, 1, 0, 32'h88542cb1); step();
        chk_dump("d2.b1h1", 1, 1, 0, 32'h88542cb1); step();
        chk_dump("d2.b1h2", 1, 1, 0, 32'h88542cb1);
        dump_ready = 1; step();
        chk_dump("d2.b2", 1, 1, 0, 32'h23a33939); step();
        chk_dump("d2.b3", 1, 1, 0, 32'h2a6c7605);
        dump_ready = 0; step();
        chk_dump("d2.b3h", 1, 1, 0, 32'h2a6c7605);
        dump_ready = 1; step();
        chk_dump("d2.done", 0, 0, 1, 32'h0); step();
        chk_dump("d2.idle", 0, 0, 0, 32'h0);
        read = 1; addr = 16'h0010; step(); read = 0;
        chk("d2.w1new", read_data, W2);

        // Reset during D_SEND
        dump = 1; dump_num = 3'd1; dump_ready = 0; step(); dump = 0;
        chk("d3.busy", 128'(dump_busy), 1);
        #1 n_rst = 1'b0;
        #1;
        chk_dump("d3.rst", 0, 0, 0, 32'h0);
        chk("d3.rst_rd", read_data, '0);
        step(); n_rst = 1'b1; dump_ready = 1;
        step();
        chk_dump("d3.after", 0, 0, 0, 32'h0);
        read = 1; addr = 16'h0010; step(); read = 0;
        chk("d3.w1zero", read_data, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
